// File: rtl/ldpc_min2_tree_if.sv
// Beat/result bus for the LDPC check-node min1/min2 search.
// master: drives the beat (i_valid, i_last, i_in_data) and receives the row result.
// slave : receives the beat and drives o_valid, o_min1, o_min2, o_min1_index, o_error.
interface ldpc_min2_tree_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned MAX_BEATS  = 4
);
  localparam int unsigned IDX_RAW = $clog2(NUM_INPUTS * MAX_BEATS);
  localparam int unsigned IDX_W   = (IDX_RAW < 1) ? 1 : IDX_RAW;

  logic                        i_valid;
  logic                        i_last;
  logic [NUM_INPUTS*WIDTH-1:0] i_in_data;
  logic                        o_valid;
  logic [WIDTH-1:0]            o_min1;
  logic [WIDTH-1:0]            o_min2;
  logic [IDX_W-1:0]            o_min1_index;
  logic                        o_error;

  modport master (
    output i_valid, i_last, i_in_data,
    input  o_valid, o_min1, o_min2, o_min1_index, o_error
  );

  modport slave (
    input  i_valid, i_last, i_in_data,
    output o_valid, o_min1, o_min2, o_min1_index, o_error
  );
endinterface

// File: rtl/ldpc_min2_tree.sv
// Pipelined check-node magnitude search: per row, the smallest value (min1),
// the second-smallest value (min2) and the global index of min1. A row is one
// or more beats of NUM_INPUTS unsigned values; one beat is accepted per clock.
// Ports:
//   i_clock - rising-edge clock
//   i_reset - asynchronous active-high reset
//   bus     - slave side of ldpc_min2_tree_if (beat in, row result out)
// Latency from a last beat to o_valid is $clog2(NUM_INPUTS) + 1 cycles.
module ldpc_min2_tree #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NUM_INPUTS = 8,
  parameter int unsigned MAX_BEATS  = 4
) (
  input logic             i_clock,
  input logic             i_reset,
  ldpc_min2_tree_if.slave bus
);
  localparam int unsigned STAGES  = $clog2(NUM_INPUTS);
  localparam int unsigned LANES   = 1 << STAGES;
  localparam int unsigned IDX_RAW = $clog2(NUM_INPUTS * MAX_BEATS);
  localparam int unsigned IDX_W   = (IDX_RAW < 1) ? 1 : IDX_RAW;
  localparam int unsigned NODE_W  = 2 * WIDTH + IDX_W;
  localparam int unsigned CNT_W   = $clog2(MAX_BEATS + 1);

  // Node layout: {min1, min2, idx}
  typedef logic [NODE_W-1:0] node_t;

  function automatic node_t pack_node(input logic [WIDTH-1:0] m1, input logic [WIDTH-1:0] m2,
                                      input logic [IDX_W-1:0] idx);
    return {m1, m2, idx};
  endfunction

  function automatic logic [WIDTH-1:0] node_min1(input node_t n);
    return n[NODE_W-1 -: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] node_min2(input node_t n);
    return n[IDX_W+WIDTH-1 -: WIDTH];
  endfunction

  function automatic logic [IDX_W-1:0] node_idx(input node_t n);
    return n[IDX_W-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] min_val(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b < a) ? b : a;
  endfunction

  // x sits at the lower index, so it keeps min1 on a tie
  function automatic node_t leaf_pair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic [IDX_W-1:0] idx_x);
    if (y < x) return pack_node(y, x, idx_x + IDX_W'(1));
    else       return pack_node(x, y, idx_x);
  endfunction

  // a covers lower indices than b; b must be strictly smaller to win
  function automatic node_t merge_nodes(input node_t a, input node_t b);
    if (node_min1(b) < node_min1(a))
      return pack_node(node_min1(b), min_val(node_min1(a), node_min2(b)), node_idx(b));
    else
      return pack_node(node_min1(a), min_val(node_min1(b), node_min2(a)), node_idx(a));
  endfunction

  // Leaf lanes, padded to a power of two with all-ones values
  logic [WIDTH-1:0] lane [LANES];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    if (k < NUM_INPUTS) begin : g_real
      assign lane[k] = bus.i_in_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign lane[k] = '1;
    end
  end

  // Valid/last flags travel alongside the tree data
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES-1:0] lst_pipe;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.i_valid;
      lst_pipe[0] <= bus.i_valid & bus.i_last;
      for (int s = 1; s < int'(STAGES); s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        lst_pipe[s] <= lst_pipe[s-1];
      end
    end
  end

  // Reduction tree: stage 0 pairs leaves, each later stage merges node pairs
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned NODES = LANES >> (s + 1);
    node_t node [NODES];

    if (s == 0) begin : g_leaf
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          for (int j = 0; j < int'(NODES); j++) node[j] <= '0;
        end else begin
          for (int j = 0; j < int'(NODES); j++)
            node[j] <= leaf_pair(lane[2*j], lane[2*j+1], IDX_W'(2*j));
        end
      end
    end else begin : g_merge
      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          for (int j = 0; j < int'(NODES); j++) node[j] <= '0;
        end else begin
          for (int j = 0; j < int'(NODES); j++)
            node[j] <= merge_nodes(g_stage[s-1].node[2*j], g_stage[s-1].node[2*j+1]);
        end
      end
    end
  end

  node_t tree_out;
  logic  tree_valid;
  logic  tree_last;

  assign tree_out   = g_stage[STAGES-1].node[0];
  assign tree_valid = vld_pipe[STAGES-1];
  assign tree_last  = lst_pipe[STAGES-1];

  // Row accumulator state
  node_t            acc;
  logic             acc_full;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_flag;

  node_t beat_node;
  node_t merged;
  node_t result;
  logic  in_range;
  logic  take;
  logic  err_next;

  // Beat merge: beat is the higher-index operand, its idx offset by its beat position
  always_comb begin
    beat_node = pack_node(node_min1(tree_out), node_min2(tree_out),
                          node_idx(tree_out) + IDX_W'(32'(beat_cnt) * NUM_INPUTS));
    in_range  = (beat_cnt < CNT_W'(MAX_BEATS));
    merged    = acc_full ? merge_nodes(acc, beat_node) : beat_node;
    take      = tree_valid & in_range;
    result    = take ? merged : acc;
    err_next  = err_flag | (tree_valid & ~in_range);
  end

  // Accumulator update and registered row result
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      acc              <= '0;
      acc_full         <= 1'b0;
      beat_cnt         <= '0;
      err_flag         <= 1'b0;
      bus.o_valid      <= 1'b0;
      bus.o_min1       <= '0;
      bus.o_min2       <= '0;
      bus.o_min1_index <= '0;
      bus.o_error      <= 1'b0;
    end else begin
      bus.o_valid <= tree_valid & tree_last;
      if (tree_valid & tree_last) begin
        bus.o_min1       <= node_min1(result);
        bus.o_min2       <= node_min2(result);
        bus.o_min1_index <= node_idx(result);
        bus.o_error      <= err_next;
        acc              <= '0;
        acc_full         <= 1'b0;
        beat_cnt         <= '0;
        err_flag         <= 1'b0;
      end else if (take) begin
        acc      <= merged;
        acc_full <= 1'b1;
        beat_cnt <= beat_cnt + CNT_W'(1);
      end else if (tree_valid) begin
        // Beat beyond MAX_BEATS: dropped, row marked in error
        err_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ldpc_min2_tree.sv
// Scoreboard bench for ldpc_min2_tree: an 8-input and a 5-input instance are
// driven with directed and random rows; expected results are queued at issue
// time and popped by a monitor whenever a DUT raises o_valid.
module tb_ldpc_min2_tree;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned MB    = 4;
  localparam int unsigned N8    = 8;
  localparam int unsigned N5    = 5;
  localparam int          LAT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ldpc_min2_tree_if #(.WIDTH(WIDTH), .NUM_INPUTS(N8), .MAX_BEATS(MB)) b8();
  ldpc_min2_tree_if #(.WIDTH(WIDTH), .NUM_INPUTS(N5), .MAX_BEATS(MB)) b5();

  ldpc_min2_tree #(.WIDTH(WIDTH), .NUM_INPUTS(N8), .MAX_BEATS(MB)) dut8 (
    .i_clock(clk), .i_reset(rst), .bus(b8)
  );
  ldpc_min2_tree #(.WIDTH(WIDTH), .NUM_INPUTS(N5), .MAX_BEATS(MB)) dut5 (
    .i_clock(clk), .i_reset(rst), .bus(b5)
  );

  typedef struct {
    int min1;
    int min2;
    int idx;
    bit err;
    int due;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   row8[$];
  int   row5[$];
  int   beats8 = 0;
  int   beats5 = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   run8 = 0;
  int   max_run8 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: over the first MAX_BEATS beats, sorted values give min1/min2;
  // the first occurrence of min1 gives the index.
  function automatic exp_t ref_row(input int vals[$], input int beats, input int due);
    exp_t r;
    int   s[$];
    s = vals;
    s.sort();
    r.min1 = s[0];
    r.min2 = s[1];
    r.idx  = 0;
    for (int i = vals.size() - 1; i >= 0; i--)
      if (vals[i] == s[0]) r.idx = i;
    r.err = (beats > int'(MB));
    r.due = due;
    return r;
  endfunction

  task automatic push_const(input bit sel5, input int m1, input int m2, input int idx, input bit err);
    exp_t e;
    e.min1 = m1;
    e.min2 = m2;
    e.idx  = idx;
    e.err  = err;
    e.due  = cyc + LAT;
    if (sel5) q5.push_back(e);
    else      q8.push_back(e);
  endtask

  task automatic send_beat(input bit sel5, input int vals[$], input bit last, input bit auto_exp);
    @(negedge clk);
    b8.i_valid = 1'b0;
    b8.i_last  = 1'b0;
    b5.i_valid = 1'b0;
    b5.i_last  = 1'b0;
    if (!sel5) begin
      b8.i_valid = 1'b1;
      b8.i_last  = last;
      for (int k = 0; k < int'(N8); k++) b8.i_in_data[k*WIDTH +: WIDTH] = WIDTH'(vals[k]);
      if (beats8 < int'(MB))
        for (int k = 0; k < int'(N8); k++) row8.push_back(vals[k]);
      beats8++;
      if (last) begin
        if (auto_exp) q8.push_back(ref_row(row8, beats8, cyc + LAT));
        row8.delete();
        beats8 = 0;
      end
    end else begin
      b5.i_valid = 1'b1;
      b5.i_last  = last;
      for (int k = 0; k < int'(N5); k++) b5.i_in_data[k*WIDTH +: WIDTH] = WIDTH'(vals[k]);
      if (beats5 < int'(MB))
        for (int k = 0; k < int'(N5); k++) row5.push_back(vals[k]);
      beats5++;
      if (last) begin
        if (auto_exp) q5.push_back(ref_row(row5, beats5, cyc + LAT));
        row5.delete();
        beats5 = 0;
      end
    end
  endtask

  // Idle cycles carry junk data and a random i_last, which must be ignored
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      b8.i_valid   = 1'b0;
      b5.i_valid   = 1'b0;
      b8.i_last    = 1'($urandom_range(0, 1));
      b5.i_last    = 1'($urandom_range(0, 1));
      b8.i_in_data = 128'({$urandom(), $urandom(), $urandom(), $urandom()});
      b5.i_in_data = 80'({$urandom(), $urandom(), $urandom()});
    end
  endtask

  task automatic rand_row(input bit sel5, input int nbeats);
    int n;
    int mode;
    int vals[$];
    n = sel5 ? int'(N5) : int'(N8);
    mode = $urandom_range(0, 9);
    for (int b = 0; b < nbeats; b++) begin
      vals.delete();
      for (int k = 0; k < n; k++) begin
        if (mode < 6)      vals.push_back(int'($urandom_range(0, 15)));
        else if (mode < 9) vals.push_back(int'($urandom_range(0, 65535)));
        else               vals.push_back(65535);
      end
      send_beat(sel5, vals, (b == nbeats - 1), 1'b1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic check_cleared(input string nm, input logic v, input int m1, input int m2,
                               input int idx, input logic err);
    checks++;
    if (v !== 1'b0 || m1 != 0 || m2 != 0 || idx != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s: got valid=%0b min1=%0d min2=%0d idx=%0d err=%0b, required all zero",
               nm, v, m1, m2, idx, err);
    end
  endtask

  task automatic compare(input string nm, input bit have, input exp_t e, input int m1,
                         input int m2, input int idx, input bit err);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s unexpected o_valid at cycle %0d: got min1=%0d min2=%0d idx=%0d err=%0d, required no result",
               nm, cyc, m1, m2, idx, err);
    end else if (m1 != e.min1 || m2 != e.min2 || idx != e.idx || err != e.err || cyc != e.due) begin
      failures++;
      $display("FAIL %s row result: got min1=%0d min2=%0d idx=%0d err=%0d cycle=%0d, required min1=%0d min2=%0d idx=%0d err=%0d cycle=%0d",
               nm, m1, m2, idx, err, cyc, e.min1, e.min2, e.idx, e.err, e.due);
    end
  endtask

  // Monitor: pops one expectation per o_valid pulse
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    if (!rst) begin
      if (b8.o_valid) begin
        run8++;
        if (run8 > max_run8) max_run8 = run8;
        e = '{default: 0};
        have = (q8.size() > 0);
        if (have) e = q8.pop_front();
        compare("dut8", have, e, 32'(b8.o_min1), 32'(b8.o_min2), 32'(b8.o_min1_index), b8.o_error);
      end else begin
        run8 = 0;
      end
      if (b5.o_valid) begin
        e = '{default: 0};
        have = (q5.size() > 0);
        if (have) e = q5.pop_front();
        compare("dut5", have, e, 32'(b5.o_min1), 32'(b5.o_min2), 32'(b5.o_min1_index), b5.o_error);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v[$];
    b8.i_valid = 1'b0; b8.i_last = 1'b0; b8.i_in_data = '0;
    b5.i_valid = 1'b0; b5.i_last = 1'b0; b5.i_in_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset8", b8.o_valid, 32'(b8.o_min1), 32'(b8.o_min2), 32'(b8.o_min1_index), b8.o_error);
    check_cleared("reset5", b5.o_valid, 32'(b5.o_min1), 32'(b5.o_min2), 32'(b5.o_min1_index), b5.o_error);
    rst = 1'b0;
    idle(2);

    // Single beat with tied minima
    v = {7, 3, 9, 3, 12, 1, 5, 1};
    send_beat(1'b0, v, 1'b1, 1'b0);
    push_const(1'b0, 1, 1, 5, 1'b0);
    idle(6);

    // Two-beat row, min1 in the second beat
    v = {9, 9, 4, 9, 9, 9, 9, 9};
    send_beat(1'b0, v, 1'b0, 1'b0);
    v = {9, 9, 9, 2, 9, 9, 9, 9};
    send_beat(1'b0, v, 1'b1, 1'b0);
    push_const(1'b0, 2, 4, 11, 1'b0);
    idle(8);

    // 20 back-to-back single-beat rows
    max_run8 = 0;
    for (int r = 0; r < 20; r++) begin
      v.delete();
      for (int k = 0; k < int'(N8); k++) v.push_back(int'($urandom_range(0, 31)));
      send_beat(1'b0, v, 1'b1, 1'b1);
    end
    idle(8);
    checks++;
    if (max_run8 != 20) begin
      failures++;
      $display("FAIL back_to_back_run: got %0d consecutive o_valid cycles, required 20", max_run8);
    end

    // Non-power-of-two width: padded lanes must never win
    v = {9, 9, 9, 9, 2};
    send_beat(1'b1, v, 1'b1, 1'b0);
    push_const(1'b1, 2, 9, 4, 1'b0);
    v = {65535, 65535, 65535, 65535, 65535};
    send_beat(1'b1, v, 1'b1, 1'b0);
    push_const(1'b1, 65535, 65535, 0, 1'b0);
    idle(6);

    // Over-long row: fifth beat carries a 0 that must be excluded
    for (int b = 0; b < 5; b++) begin
      v.delete();
      for (int k = 0; k < int'(N8); k++) v.push_back(100 - b * 8 - k);
      if (b == 4) v[3] = 0;
      send_beat(1'b0, v, (b == 4), 1'b0);
    end
    push_const(1'b0, 69, 70, 31, 1'b1);
    v = {4, 4, 4, 4, 4, 4, 4, 4};
    send_beat(1'b0, v, 1'b1, 1'b0);
    push_const(1'b0, 4, 4, 0, 1'b0);
    idle(8);

    // Reset with a finished row in flight and a partial row accumulated
    v = {1, 2, 3, 4, 5, 6, 7, 8};
    send_beat(1'b0, v, 1'b1, 1'b1);
    send_beat(1'b0, v, 1'b0, 1'b1);
    send_beat(1'b0, v, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    b8.i_valid = 1'b0;
    b5.i_valid = 1'b0;
    q8.delete(); q5.delete();
    row8.delete(); row5.delete();
    beats8 = 0; beats5 = 0;
    @(negedge clk);
    check_cleared("midrow_reset8", b8.o_valid, 32'(b8.o_min1), 32'(b8.o_min2), 32'(b8.o_min1_index), b8.o_error);
    rst = 1'b0;
    v = {5, 6, 7, 8, 1, 2, 3, 4};
    send_beat(1'b0, v, 1'b1, 1'b0);
    push_const(1'b0, 1, 2, 4, 1'b0);
    idle(8);

    // Random rows on both instances, including over-long rows and gaps
    for (int r = 0; r < 300; r++)
      rand_row(1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
    idle(LAT + 6);

    checks++;
    if (q8.size() != 0 || q5.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d results still pending, required 0/0", q8.size(), q5.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
